// File: rtl/cache_controller.sv
// cache_controller
//   2-way set-associative, write-through, no-write-allocate read cache that sits
//   between the MEM stage and the SRAM controller. Read hits complete in the
//   request cycle. Read misses fetch a 64-bit line. Every write is forwarded to
//   SRAM as a single word. ready_out replaces the raw SRAM ready as the pipeline
//   freeze signal.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd_en_in, wr_en_in       MEM-stage read/write request, held until ready_out=1
//   addr_in, wdata_in        byte address (bits [1:0] ignored), store data
//   rdata_out, ready_out     load data, done/idle flag (0 freezes the pipeline)
//   sram_rd_en, sram_wr_en   line read / word write request to the SRAM controller
//   sram_addr, sram_wdata    registered SRAM address and write data
//   sram_rdata, sram_ready   line data {word1, word0}, one-cycle completion pulse
//   hit_cnt, miss_cnt        saturating read hit/miss counters
module cache_controller #(
    parameter int SET_BITS = 6,
    parameter int TAG_BITS = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en_in,
    input  logic             wr_en_in,
    input  logic [31:0]      addr_in,
    input  logic [31:0]      wdata_in,
    output logic [31:0]      rdata_out,
    output logic             ready_out,
    output logic             sram_rd_en,
    output logic             sram_wr_en,
    output logic [31:0]      sram_addr,
    output logic [31:0]      sram_wdata,
    input  logic [63:0]      sram_rdata,
    input  logic             sram_ready,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int SETS = 1 << SET_BITS;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

    state_t state, state_nxt;

    // Control state: reset on rst.
    logic [SETS-1:0] valid0, valid1;
    logic [SETS-1:0] lru;               // index of the least-recently-used way

    // Storage arrays: never reset, qualified by the valid bits.
    logic [TAG_BITS-1:0] tag0  [SETS];
    logic [TAG_BITS-1:0] tag1  [SETS];
    logic [63:0]         data0 [SETS];
    logic [63:0]         data1 [SETS];

    logic [SET_BITS-1:0] set_idx;
    logic [TAG_BITS-1:0] tag_in;
    logic                word_sel;
    logic                hit0, hit1, hit;
    logic [63:0]         hit_line;
    logic                victim;
    logic                unused_addr_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] line, input logic w);
        return w ? line[63:32] : line[31:0];
    endfunction

    // The request is held stable for its whole lifetime, so the lookup can use
    // addr_in directly in every state.
    assign set_idx          = addr_in[SET_BITS+2:3];
    assign tag_in           = addr_in[TAG_BITS+SET_BITS+2:SET_BITS+3];
    assign word_sel         = addr_in[2];
    assign unused_addr_bits = ^addr_in[1:0];

    assign hit0     = valid0[set_idx] && (tag0[set_idx] == tag_in);
    assign hit1     = valid1[set_idx] && (tag1[set_idx] == tag_in);
    assign hit      = hit0 || hit1;
    assign hit_line = hit0 ? data0[set_idx] : data1[set_idx];

    // Fill an empty way first, otherwise replace the LRU way.
    assign victim = !valid0[set_idx] ? 1'b0 :
                    !valid1[set_idx] ? 1'b1 : lru[set_idx];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a write wins over a simultaneous read.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_en_in)               state_nxt = WR;
                else if (rd_en_in && !hit)  state_nxt = RD_MISS;
            end
            RD_MISS: if (sram_ready) state_nxt = IDLE;
            WR:      if (sram_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; SRAM strobes depend on state only.
    always_comb begin
        ready_out  = 1'b1;
        rdata_out  = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        case (state)
            IDLE: begin
                if (wr_en_in) begin
                    ready_out = 1'b0;
                end else if (rd_en_in) begin
                    if (hit) rdata_out = word_of(hit_line, word_sel);
                    else     ready_out = 1'b0;
                end
            end
            RD_MISS: begin
                sram_rd_en = 1'b1;
                ready_out  = sram_ready;
                if (sram_ready) rdata_out = word_of(sram_rdata, word_sel);
            end
            WR: begin
                sram_wr_en = 1'b1;
                ready_out  = sram_ready;
            end
            default: ready_out = 1'b1;
        endcase
    end

    // Control registers: valid/LRU bits, counters, SRAM address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid0     <= '0;
            valid1     <= '0;
            lru        <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en_in) begin
                        sram_addr  <= {addr_in[31:2], 2'b00};
                        sram_wdata <= wdata_in;
                    end else if (rd_en_in) begin
                        if (hit) begin
                            lru[set_idx] <= hit0;   // the other way becomes LRU
                            hit_cnt      <= sat_inc(hit_cnt);
                        end else begin
                            miss_cnt  <= sat_inc(miss_cnt);
                            sram_addr <= {addr_in[31:3], 3'b000};
                        end
                    end
                end
                RD_MISS: begin
                    if (sram_ready) begin
                        if (victim) valid1[set_idx] <= 1'b1;
                        else        valid0[set_idx] <= 1'b1;
                        lru[set_idx] <= ~victim;
                    end
                end
                WR: begin
                    if (sram_ready && hit) lru[set_idx] <= hit0;
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays: line fill on a read miss, word update on a write hit.
    always_ff @(posedge clk) begin
        if (state == RD_MISS && sram_ready) begin
            if (victim) begin
                tag1[set_idx]  <= tag_in;
                data1[set_idx] <= sram_rdata;
            end else begin
                tag0[set_idx]  <= tag_in;
                data0[set_idx] <= sram_rdata;
            end
        end else if (state == WR && sram_ready && hit) begin
            if (hit0) begin
                if (word_sel) data0[set_idx][63:32] <= sram_wdata;
                else          data0[set_idx][31:0]  <= sram_wdata;
            end else begin
                if (word_sel) data1[set_idx][63:32] <= sram_wdata;
                else          data1[set_idx][31:0]  <= sram_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller. The bench plays the SRAM controller itself,
// backed by a word memory; expected load data is queued when a read is issued
// and compared when the cache reports ready.
module tb_cache_controller;

    localparam int CW = 4;   // narrow counters so saturation is reachable

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_en_in, wr_en_in;
    logic [31:0]   addr_in, wdata_in;
    logic [31:0]   rdata_out;
    logic          ready_out;
    logic          sram_rd_en, sram_wr_en;
    logic [31:0]   sram_addr, sram_wdata;
    logic [63:0]   sram_rdata;
    logic          sram_ready;
    logic [CW-1:0] hit_cnt, miss_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q [$];
    logic [31:0] mem [logic [31:0]];
    int          exp_hits = 0;
    int          exp_miss = 0;

    cache_controller #(.SET_BITS(6), .TAG_BITS(10), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rd_en_in(rd_en_in), .wr_en_in(wr_en_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .rdata_out(rdata_out), .ready_out(ready_out),
        .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {16'hC0DE, a[15:0]};
    endfunction

    function automatic int sat(input int v);
        return (v == (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_counters();
        check("hit_cnt", 64'(hit_cnt), 64'(exp_hits));
        check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
    endtask

    task automatic do_read(input logic [31:0] a, input bit exp_hit);
        logic [31:0] base;
        @(posedge clk); #1;
        rd_en_in = 1'b1;
        addr_in  = a;
        exp_q.push_back(mem_word({a[31:2], 2'b00}));
        if (exp_hit) exp_hits = sat(exp_hits);
        else         exp_miss = sat(exp_miss);
        @(negedge clk);
        check("req_ready", 64'(ready_out), 64'(exp_hit));
        if (exp_hit) begin
            check("hit_no_sram", 64'(sram_rd_en), 64'd0);
            check("hit_data", 64'(rdata_out), 64'(exp_q.pop_front()));
        end else begin
            @(posedge clk); #1;
            check("miss_rd_en", 64'(sram_rd_en), 64'd1);
            check("miss_wr_en", 64'(sram_wr_en), 64'd0);
            check("miss_addr", 64'(sram_addr), 64'({a[31:3], 3'b000}));
            check("miss_wait_ready", 64'(ready_out), 64'd0);
            @(posedge clk); #1;
            check("miss_hold", 64'(sram_rd_en), 64'd1);
            base       = {a[31:3], 3'b000};
            sram_rdata = {mem_word(base + 32'd4), mem_word(base)};
            sram_ready = 1'b1;
            @(negedge clk);
            check("fill_ready", 64'(ready_out), 64'd1);
            check("fill_data", 64'(rdata_out), 64'(exp_q.pop_front()));
        end
        @(posedge clk); #1;
        rd_en_in   = 1'b0;
        sram_ready = 1'b0;
        check_counters();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit with_rd);
        @(posedge clk); #1;
        wr_en_in = 1'b1;
        rd_en_in = with_rd;
        addr_in  = a;
        wdata_in = d;
        @(negedge clk);
        check("wr_req_ready", 64'(ready_out), 64'd0);
        @(posedge clk); #1;
        check("wr_en", 64'(sram_wr_en), 64'd1);
        check("wr_no_rd", 64'(sram_rd_en), 64'd0);
        check("wr_addr", 64'(sram_addr), 64'({a[31:2], 2'b00}));
        check("wr_data", 64'(sram_wdata), 64'(d));
        mem[{a[31:2], 2'b00}] = d;
        sram_ready = 1'b1;
        @(negedge clk);
        check("wr_done_ready", 64'(ready_out), 64'd1);
        @(posedge clk); #1;
        wr_en_in   = 1'b0;
        rd_en_in   = 1'b0;
        sram_ready = 1'b0;
        check_counters();
    endtask

    initial begin
        rst        = 1'b1;
        rd_en_in   = 1'b0;
        wr_en_in   = 1'b0;
        addr_in    = '0;
        wdata_in   = '0;
        sram_rdata = '0;
        sram_ready = 1'b0;
        mem[32'h408] = 32'hAAAAAAAA;
        mem[32'h40C] = 32'hBBBBBBBB;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_rdata", 64'(rdata_out), 64'd0);
        check("rst_sram_rd", 64'(sram_rd_en), 64'd0);
        check("rst_sram_wr", 64'(sram_wr_en), 64'd0);
        check("rst_sram_addr", 64'(sram_addr), 64'd0);
        check("rst_sram_wdata", 64'(sram_wdata), 64'd0);
        check_counters();

        // Cold miss then hit on the other word of the same line
        do_read(32'h408, 1'b0);
        do_read(32'h40C, 1'b1);

        // Set 1 replacement: the LRU way is evicted
        do_read(32'h008, 1'b0);
        do_read(32'h208, 1'b0);
        do_read(32'h008, 1'b1);
        do_read(32'h408, 1'b0);
        do_read(32'h008, 1'b1);
        do_read(32'h208, 1'b0);

        // Write-through to a cached word; neighbour word untouched
        do_write(32'h008, 32'h12345678, 1'b0);
        do_read(32'h008, 1'b1);
        do_read(32'h00C, 1'b1);

        // Uncached write does not allocate
        do_write(32'h800, 32'hCAFEF00D, 1'b0);
        do_read(32'h800, 1'b0);

        // Read and write together take the write path and update the cached line
        do_write(32'h804, 32'h5A5A5A5A, 1'b1);
        do_read(32'h804, 1'b1);

        // Hit counter saturation
        for (int i = 0; i < 10; i++) do_read(32'h008, 1'b1);
        check("hit_cnt_sat", 64'(hit_cnt), 64'hF);

        // Reset in the middle of a miss
        @(posedge clk); #1;
        rd_en_in = 1'b1;
        addr_in  = 32'h600;
        @(negedge clk);
        check("rm_req_ready", 64'(ready_out), 64'd0);
        @(posedge clk); #1;
        check("rm_rd_en", 64'(sram_rd_en), 64'd1);
        rst      = 1'b1;
        rd_en_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        check("rm_sram_rd", 64'(sram_rd_en), 64'd0);
        check("rm_ready", 64'(ready_out), 64'd1);
        check("rm_sram_addr", 64'(sram_addr), 64'd0);
        check_counters();
        do_read(32'h008, 1'b0);
        do_read(32'h008, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
